// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM states, YCbCr pixel, colour bars, line/frame sizing.
// Used by the transmit block (pattern source under DVP_TX_PATTERN_EN) and capture.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } tx_state_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycbcr_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_BLANK_DEF  = 144;
    localparam int VS_LINES_DEF = 3;
    localparam int V_BACK_DEF   = 17;
    localparam int V_FRONT_DEF  = 10;

    function automatic int line_len(input int h_active, input int h_blank);
        return 2 * h_active + h_blank;
    endfunction

    function automatic int frame_lines(input int vs, input int vb,
                                       input int va, input int vf);
        return vs + vb + va + vf;
    endfunction

    // White, yellow, cyan, green, magenta, red, blue, black
    function automatic ycbcr_t bar_pixel(input logic [2:0] idx);
        ycbcr_t p;
        unique case (idx)
            3'd0: p = '{y: 8'd235, cb: 8'd128, cr: 8'd128};
            3'd1: p = '{y: 8'd210, cb: 8'd16,  cr: 8'd146};
            3'd2: p = '{y: 8'd170, cb: 8'd166, cr: 8'd16};
            3'd3: p = '{y: 8'd145, cb: 8'd54,  cr: 8'd34};
            3'd4: p = '{y: 8'd106, cb: 8'd202, cr: 8'd222};
            3'd5: p = '{y: 8'd81,  cb: 8'd90,  cr: 8'd240};
            3'd6: p = '{y: 8'd41,  cb: 8'd240, cr: 8'd110};
            3'd7: p = '{y: 8'd16,  cb: 8'd128, cr: 8'd128};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// DVP transmit timing: byte/line counters, region FSM, registered vsync/href.
// Exposes pixel column for the colour-bar source when DVP_TX_PATTERN_EN is set.
module dvp_tx_timing
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int VS_LINES = VS_LINES_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
    output tx_state_t   region,
    output logic [1:0]  phase,
`ifdef DVP_TX_PATTERN_EN
    output logic [15:0] pix_x,
`endif
    output logic        rd_pre,
    output logic        sof,
    output logic        vsync,
    output logic        href,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int LL = line_len(H_ACTIVE, H_BLANK);
    localparam int FL = frame_lines(VS_LINES, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic [15:0] BYTE_LAST = 16'(LL - 1);
    localparam logic [15:0] ACT_LAST  = 16'(2 * H_ACTIVE - 1);
    localparam logic [11:0] VS_END    = 12'(VS_LINES - 1);
    localparam logic [11:0] VB_END    = 12'(VS_LINES + V_BACK - 1);
    localparam logic [11:0] VA_END    = 12'(VS_LINES + V_BACK + V_ACTIVE - 1);
    localparam logic [11:0] VF_END    = 12'(FL - 1);

    tx_state_t   state;
    logic [15:0] bcnt;
    logic [11:0] lcnt;
    logic        line_end;

    // Counters describe the byte being prepared; outputs show it one edge later.
    always_comb begin
        region = state;
        if (state == IDLE && enable) region = VSYNC;
    end

    assign line_end = (bcnt == BYTE_LAST);
    assign phase    = bcnt[1:0];
    assign sof      = (region == VSYNC) && (lcnt == '0) && (bcnt == '0);

`ifdef DVP_TX_PATTERN_EN
    assign pix_x = {1'b0, bcnt[15:2], bcnt[0]};
`endif

    // Fetch pixel 2p on the byte before each pair begins.
    assign rd_pre = (region == ACTIVE && bcnt[1:0] == 2'd3 && bcnt != ACT_LAST)
                 || (line_end && region == VBACK && lcnt == VB_END)
                 || (line_end && region == HBLANK && lcnt != VA_END);

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bcnt        <= '0;
            lcnt        <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vsync       <= (region == VSYNC);
            href        <= (region == ACTIVE);
            frame_start <= sof;
            frame_done  <= (region == VFRONT) && line_end && (lcnt == VF_END);
            busy        <= (region != IDLE);
            if (region != IDLE) begin
                bcnt <= line_end ? '0 : bcnt + 16'd1;
                if (line_end)
                    lcnt <= (lcnt == VF_END) ? '0 : lcnt + 12'd1;
                unique case (region)
                    VSYNC:
                        state <= (line_end && lcnt == VS_END) ? VBACK : VSYNC;
                    VBACK:
                        if (line_end && lcnt == VB_END) state <= ACTIVE;
                    ACTIVE:
                        if (bcnt == ACT_LAST) state <= HBLANK;
                    HBLANK:
                        if (line_end)
                            state <= (lcnt == VA_END) ? VFRONT : ACTIVE;
                    VFRONT:
                        if (line_end && lcnt == VF_END)
                            state <= enable ? VSYNC : IDLE;
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP frame transmitter: streams stored YCbCr 4:2:2 frames as Cb Y Cr Y bytes.
// DVP_TX_PATTERN_EN adds pattern_sel, selecting an internal colour-bar source.
module dvp_frame_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int H_BLANK  = H_BLANK_DEF,
    parameter int VS_LINES = VS_LINES_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
`ifdef DVP_TX_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        mem_rd_en,
    output logic [19:0] mem_rd_addr,
    input  logic [23:0] mem_rd_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  byte_out,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    tx_state_t  region;
    logic [1:0] phase;
    logic       rd_pre;
    logic       sof;
    logic       rd_req;
    ycbcr_t     mem_pix;
    ycbcr_t     pix;
    logic [7:0] y0_q;
    logic [7:0] cr_q;
    logic [7:0] y1_q;

`ifdef DVP_TX_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [15:0] pix_x;
    logic [2:0]  bar;
    logic        pat_on;
`endif

    dvp_tx_timing #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .enable      (enable),
        .region      (region),
        .phase       (phase),
`ifdef DVP_TX_PATTERN_EN
        .pix_x       (pix_x),
`endif
        .rd_pre      (rd_pre),
        .sof         (sof),
        .vsync       (vsync),
        .href        (href),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    assign mem_pix = ycbcr_t'(mem_rd_data);
    assign rd_req  = rd_pre || (region == ACTIVE && phase == 2'd0);

`ifdef DVP_TX_PATTERN_EN
    assign bar       = 3'(pix_x / 16'(BAR_W));
    assign pix       = pat_on ? bar_pixel(bar) : mem_pix;
    assign mem_rd_en = rd_req && !pat_on;

    always_ff @(posedge pclk) begin
        if (!reset_n)
            pat_on <= 1'b0;
        else if (sof)
            pat_on <= pattern_sel;
    end
`else
    assign pix       = mem_pix;
    assign mem_rd_en = rd_req;
`endif

    // Phase 0 consumes pixel 2p; phase 1 consumes 2p+1 arriving a cycle later.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            mem_rd_addr <= '0;
            byte_out    <= '0;
            y0_q        <= '0;
            cr_q        <= '0;
            y1_q        <= '0;
        end else begin
            if (sof)
                mem_rd_addr <= '0;
            else if (mem_rd_en)
                mem_rd_addr <= mem_rd_addr + 20'd1;
            byte_out <= '0;
            if (region == ACTIVE) begin
                unique case (phase)
                    2'd0: begin
                        byte_out <= pix.cb;
                        y0_q     <= pix.y;
                        cr_q     <= pix.cr;
                    end
                    2'd1: begin
                        byte_out <= y0_q;
                        y1_q     <= pix.y;
                    end
                    2'd2: byte_out <= cr_q;
                    2'd3: byte_out <= y1_q;
                endcase
            end
        end
    end

endmodule
